// File: rtl/hb_fir_pkg.sv
// Shared constants for the 15-tap halfband prototype used by the x2
// interpolator and the x2 decimator stages.
package hb_fir_pkg;

  localparam int COEF_WIDTH   = 18;
  localparam int NUM_E0_TAPS  = 8;
  localparam int NUM_PREADD   = NUM_E0_TAPS / 2;
  localparam int ACC_WIDTH    = 54;

  // Round half-up: add 2^(RND_SHIFT-1), then drop RND_SHIFT fraction bits.
  localparam int RND_SHIFT    = 17;
  localparam int RND_HALF     = 1 << (RND_SHIFT - 1);

  // Accept cycle to first (E0) output cycle.
  localparam int PIPE_LATENCY = 7;

  // E0 polyphase branch coefficients; sum is 65535 (DC gain 131070/131072).
  localparam logic signed [COEF_WIDTH-1:0] HB_C0 = -18'sd474;
  localparam logic signed [COEF_WIDTH-1:0] HB_C1 =  18'sd3818;
  localparam logic signed [COEF_WIDTH-1:0] HB_C2 = -18'sd16819;
  localparam logic signed [COEF_WIDTH-1:0] HB_C3 =  18'sd79010;

  typedef enum logic {
    PH_E0 = 1'b0,
    PH_E1 = 1'b1
  } hb_phase_e;

  // Coefficient for preadder pair idx: (x[m-idx] + x[m-7+idx]).
  function automatic logic signed [COEF_WIDTH-1:0] hb_coef(input int idx);
    case (idx)
      0:       return HB_C0;
      1:       return HB_C1;
      2:       return HB_C2;
      3:       return HB_C3;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/hb_round_sat.sv
// Registered round-half-up and saturate from the accumulator width down to
// the output sample width.
module hb_round_sat
  import hb_fir_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int IN_WIDTH = ACC_WIDTH
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic signed [IN_WIDTH-1:0] acc,
  output logic signed [WIDTH-1:0]    result
);

  // Head = output field MSB plus every bit above it; must be a pure sign
  // extension for the field to be representable.
  localparam int HEAD_W = IN_WIDTH - WIDTH - RND_SHIFT + 1;
  localparam logic signed [IN_WIDTH-1:0] BIAS    = IN_WIDTH'(RND_HALF);
  localparam logic signed [WIDTH-1:0]    SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]    SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0] biased;
  logic        [HEAD_W-1:0]   head;
  logic                       unused_frac;

  assign biased      = acc + BIAS;
  assign head        = biased[IN_WIDTH-1 -: HEAD_W];
  // Fraction bits are discarded by the rounding shift.
  assign unused_frac = ^biased[RND_SHIFT-1:0];

  // Take the rounded field, or clamp to full scale when it overflows.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      result <= '0;
    end else if ((&head) || (~|head)) begin
      result <= biased[WIDTH+RND_SHIFT-1:RND_SHIFT];
    end else if (biased[IN_WIDTH-1]) begin
      result <= SAT_MIN;
    end else begin
      result <= SAT_MAX;
    end
  end

endmodule

// File: rtl/hb_interp_firx2_h0.sv
// Complex x2 halfband interpolator. Each accepted sample yields an E0
// (filtered) output followed by an E1 (delayed centre tap) output.
// Channel index 0 carries I, index 1 carries Q.
module hb_interp_firx2_h0
  import hb_fir_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_inph_data,
  input  logic signed [WIDTH-1:0] i_quad_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [WIDTH-1:0] o_inph_data,
  output logic signed [WIDTH-1:0] o_quad_data,
  output logic                    o_valid,
  output logic                    o_phase
);

  localparam int PRE_W   = WIDTH + 1;
  localparam int PROD_W  = WIDTH + 19;
  localparam int SUM_W   = WIDTH + 20;
  localparam int VLD_LEN = PIPE_LATENCY - 1;  // TDL .. round stages
  localparam int E1_DLY  = PIPE_LATENCY - 2;  // preadd .. round stages

  logic                       accept;
  logic signed [WIDTH-1:0]    din     [2];
  logic signed [WIDTH-1:0]    tdl     [2][NUM_E0_TAPS];
  logic signed [PRE_W-1:0]    pre     [2][NUM_PREADD];
  logic signed [PROD_W-1:0]   prod    [2][NUM_PREADD];
  logic signed [SUM_W-1:0]    sum1    [2][2];
  logic signed [ACC_WIDTH-1:0] acc    [2];
  logic signed [WIDTH-1:0]    rnd     [2];
  logic signed [WIDTH-1:0]    e1_dly  [2][E1_DLY];
  logic signed [WIDTH-1:0]    e1_hold [2];
  logic                       e1_pend;
  logic [VLD_LEN-1:0]         vld_pipe;

  assign accept = i_valid && o_ready;
  assign din[0] = i_inph_data;
  assign din[1] = i_quad_data;

  // Ready drops for the single cycle after an accept.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ready <= 1'b1;
    end else begin
      o_ready <= ~accept;
    end
  end

  // Tap delay line, tdl[c][k] = x[m-k], shifted only on accept.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < NUM_E0_TAPS; k++)
          tdl[c][k] <= '0;
    end else if (accept) begin
      for (int c = 0; c < 2; c++) begin
        tdl[c][0] <= din[c];
        for (int k = 1; k < NUM_E0_TAPS; k++)
          tdl[c][k] <= tdl[c][k-1];
      end
    end
  end

  // Symmetric preadders.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < 2; c++)
        for (int j = 0; j < NUM_PREADD; j++)
          pre[c][j] <= '0;
    end else begin
      for (int c = 0; c < 2; c++)
        for (int j = 0; j < NUM_PREADD; j++)
          pre[c][j] <= PRE_W'(tdl[c][j]) + PRE_W'(tdl[c][NUM_E0_TAPS-1-j]);
    end
  end

  // Coefficient multipliers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < 2; c++)
        for (int j = 0; j < NUM_PREADD; j++)
          prod[c][j] <= '0;
    end else begin
      for (int c = 0; c < 2; c++)
        for (int j = 0; j < NUM_PREADD; j++)
          prod[c][j] <= PROD_W'(pre[c][j]) * PROD_W'(hb_coef(j));
    end
  end

  // Adder tree, first level: pairwise product sums.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < 2; c++) begin
        sum1[c][0] <= '0;
        sum1[c][1] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        sum1[c][0] <= SUM_W'(prod[c][0]) + SUM_W'(prod[c][1]);
        sum1[c][1] <= SUM_W'(prod[c][2]) + SUM_W'(prod[c][3]);
      end
    end
  end

  // Adder tree, second level: full accumulator.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < 2; c++)
        acc[c] <= '0;
    end else begin
      for (int c = 0; c < 2; c++)
        acc[c] <= ACC_WIDTH'(sum1[c][0]) + ACC_WIDTH'(sum1[c][1]);
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_rnd
    hb_round_sat #(
      .WIDTH    (WIDTH),
      .IN_WIDTH (ACC_WIDTH)
    ) u_rnd (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .acc     (acc[c]),
      .result  (rnd[c])
    );
  end

  // Centre tap x[m-3] delayed to line up with the rounded E0 result.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < E1_DLY; k++)
          e1_dly[c][k] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        e1_dly[c][0] <= tdl[c][3];
        for (int k = 1; k < E1_DLY; k++)
          e1_dly[c][k] <= e1_dly[c][k-1];
      end
    end
  end

  // Sample-valid tracking through the TDL..round stages.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[VLD_LEN-2:0], accept};
    end
  end

  // Output register: E0 result, then the held E1 sample on the next cycle.
  // Accepts are at least two cycles apart, so the two never collide.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_phase     <= PH_E0;
      o_inph_data <= '0;
      o_quad_data <= '0;
      e1_pend     <= 1'b0;
      e1_hold[0]  <= '0;
      e1_hold[1]  <= '0;
    end else if (vld_pipe[VLD_LEN-1]) begin
      o_valid     <= 1'b1;
      o_phase     <= PH_E0;
      o_inph_data <= rnd[0];
      o_quad_data <= rnd[1];
      e1_pend     <= 1'b1;
      e1_hold[0]  <= e1_dly[0][E1_DLY-1];
      e1_hold[1]  <= e1_dly[1][E1_DLY-1];
    end else if (e1_pend) begin
      o_valid     <= 1'b1;
      o_phase     <= PH_E1;
      o_inph_data <= e1_hold[0];
      o_quad_data <= e1_hold[1];
      e1_pend     <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
    end
  end

endmodule
